// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver. Frames have one start bit (0), eight data bits sent LSB
// first, an optional even-parity bit, and one stop bit (1). Each bit lasts CLKS_PER_BIT
// clocks, and the receiver samples each bit at its middle.
//
// Optional feature: define UART_RX_PARITY_EN to add a PARITY state and the parity_err_o port.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit; must be even and at least 4
//
// Ports:
//   clk           single clock; all logic uses the rising edge
//   reset_i       synchronous reset, active low
//   Rx            serial input line; asynchronous to clk and idles high
//   data_o        last correctly received byte
//   byte_valid_o  one-cycle pulse when data_o is updated
//   frame_err_o   one-cycle pulse when the stop bit is sampled low
//   busy_o        high whenever the FSM is not in IDLE
//   parity_err_o  one-cycle pulse on a parity mismatch (only with UART_RX_PARITY_EN)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       Rx,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] ArmSettle = CntW'(2);

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta, rx_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            full;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    assign full = (cnt_q == FullM1);

    // Synchronizer flops reset high so the line reads idle after reset.
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q <= StArm;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, together with the counter and shift-register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            // The synchronizer still holds its reset value for two cycles. Waiting out those
            // cycles makes ARM act on the real line, not on the value forced in by reset.
            StArm: begin
                cnt_d = cnt_q;
                if (cnt_q < ArmSettle) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (rx_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (full) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = StStop;
                end
            end
`endif
            // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
            StStop: begin
                if (full) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StBreak;
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StArm;
        endcase
    end

    // Outputs: busy flag and next values of the result pulses
    always_comb begin
        busy_o  = (state_q != StIdle);
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (state_q == StStop && full) begin
            if (!rx_s) begin
                ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
                perr_d = 1'b1;
`endif
            end else begin
                valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            if (valid_d) data_q <= shift_q;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_o       = data_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The stimulus process queues one expected pulse for each
// frame it sends. A separate monitor pops that entry whenever a result pulse appears, then
// checks the pulse type, data_o and the arrival cycle.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // The start bit is driven after cycle t0. The pulse is visible from cycle t0 + LAT.
    localparam int LAT = 3 + C / 2 + NB * C;

    typedef struct {
        int         kind;   // 0 = byte_valid, 1 = frame_err, 2 = parity_err
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       bv, fe, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset_i      (reset_n),
        .Rx           (rx),
        .data_o       (data),
        .byte_valid_o (bv),
        .frame_err_o  (fe),
        .busy_o       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o (parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives n bits LSB first, C cycles each. The caller is on a negedge.
    task automatic tx_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        exp_t e;
        logic [11:0] bits;
        int n;
        e.cyc = cyc + LAT;
        if (!stop) begin
            e.kind = 1;
            e.data = last_good;
`ifdef UART_RX_PARITY_EN
        end else if (par_flip) begin
            e.kind = 2;
            e.data = last_good;
`endif
        end else begin
            e.kind = 0;
            e.data = b;
            last_good = b;
        end
        sb.push_back(e);
`ifdef UART_RX_PARITY_EN
        bits = {1'b0, stop, (^b) ^ par_flip, b, 1'b0};
        n = 11;
`else
        bits = {2'b00, stop, b, 1'b0};
        n = 10;
`endif
        tx_bits(bits, n);
    endtask

    // Monitor: pops and compares on every result pulse
    always @(negedge clk) begin
        if (reset_n && (bv || fe || parity_err)) begin
            exp_t e;
            int kind;
            kind = bv ? 0 : (fe ? 1 : 2);
            check("pulse_exclusive", 32'(int'(bv) + int'(fe) + int'(parity_err)), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(kind), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(kind), 32'(e.kind));
                check("pulse_data", {24'h0, data}, {24'h0, e.data});
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_valid", {31'h0, bv}, 32'h0);
        check("rst_ferr", {31'h0, fe}, 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arm_to_idle", {31'h0, busy}, 32'h0);

        // Single frame, then two frames back to back
        send_frame(8'h05, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        send_frame(8'h05, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_final_data", {24'h0, data}, 32'h03);

        // False start: line low for 4 cycles only
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("false_start_idle", {31'h0, busy}, 32'h0);

        // Stop bit held low: frame error, then BREAK until the line returns high
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (3 * C) @(negedge clk);
        check("break_busy", {31'h0, busy}, 32'h1);
        check("break_data", {24'h0, data}, 32'h03);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_exit", {31'h0, busy}, 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        // Reset part-way through the data bits of 0x3C
        tx_bits({3'b000, 8'h3C, 1'b0}, 5);
        reset_n = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h1);
        last_good = 8'h00;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arm_hold_low", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("arm_release", {31'h0, busy}, 32'h0);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("parity_keep_data", {24'h0, data}, 32'h07);
`endif

        // Let any outstanding expectations drain, within a bounded number of cycles
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range is an even value of at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port Rx  input  1  serial line, asynchronous to clk, idles high.
REQ-005 SHALL have port data_o  output  8  last correctly received byte.
REQ-006 SHALL have port byte_valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-007 SHALL have port frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-009 SHALL have port parity_err_o  output  1  one-cycle pulse on a parity mismatch; exists only when UART_RX_PARITY_EN is defined.

Function
REQ-010 SHALL accept the frame format used by the team's UART transmitter: one start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
REQ-011 SHALL pass Rx through a 2-flop synchronizer whose flops reset high; all decoding uses the synchronized value rx_s.
REQ-012 SHALL implement the states ARM, IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-013 ARM: wait until rx_s=1, then go to IDLE, so a frame already in progress at reset release is ignored.
REQ-014 IDLE: rx_s=0 clears the bit counter and moves to START.
REQ-015 START: at count CLKS_PER_BIT/2-1, sample rx_s; 1 = false start, return to IDLE with no pulse; 0 = go to DATA with the counter cleared.
REQ-016 DATA: sample rx_s at every count CLKS_PER_BIT-1, which is mid-bit, and shift it into bit index 0..7.
REQ-016a DATA: after bit 7, go to PARITY if the macro is defined, else to STOP.
REQ-017 STOP: sample at mid-bit; on 1, load data_o from the shift register, pulse byte_valid_o, and go to IDLE.
REQ-018 STOP: on 0, pulse frame_err_o, leave data_o unchanged, and go to BREAK.
REQ-019 BREAK: stay until rx_s=1, then go to IDLE.
REQ-020 Latency: byte_valid_o SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first Rx=0 cycle, with 10*CLKS_PER_BIT used instead when the macro is defined.
REQ-021 A back-to-back frame whose start bit begins right at the end of the stop bit SHALL be received without loss, because IDLE is re-entered at mid-stop.
REQ-022 byte_valid_o, frame_err_o and parity_err_o SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-023 Rx activity seen in ARM, BREAK or mid-frame SHALL never restart the state machine.

Reset
REQ-024 While reset_i=0 at a clock edge, the block SHALL set: state=ARM, counters=0, shift register=0, data_o=0x00, all pulses=0, busy_o=1 (ARM counts as not IDLE), and synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes only after ARM sees the line high.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: the PARITY state samples one even-parity bit at mid-bit.
REQ-026a Macro defined, parity mismatch: the block pulses parity_err_o in the STOP sampling cycle instead of byte_valid_o and leaves data_o unchanged.
REQ-026b Macro defined, stop bit 0: frame_err_o takes precedence over parity_err_o.
REQ-027 Macro UART_RX_PARITY_EN undefined: the block has no PARITY state, no parity_err_o port, and a frame of 10 bits.

Verification (CLKS_PER_BIT=16)
REQ-028 Release reset with Rx=1, then send frame 0x05 -> data_o=0x05 and one byte_valid_o pulse at the cycle given by REQ-020.
REQ-029 Send 0x05 and then 0x03 back-to-back -> two pulses 160 cycles apart, with data_o ending at 0x03 and no errors.
REQ-030 Drive Rx low for 4 cycles, then high -> a false start: back to IDLE, no pulse, and busy_o low again within 12 cycles.
REQ-031 Send 0xA5 with the stop bit held 0 -> frame_err_o pulses, data_o keeps its previous value, and no new frame starts until Rx has been high.
REQ-032 Assert reset_i=0 mid-DATA of frame 0x3C -> all outputs reset, no pulse; release reset with Rx=0 -> the block stays in ARM; a later frame 0x81 -> data_o=0x81.
REQ-033 With the macro defined, send 0x07 with a correct parity bit (1) -> byte_valid_o; send 0x07 with parity bit 0 -> parity_err_o and data_o unchanged.
